fb_phase_meter: RTL
===================

FB_PHASE_METER -- requirements
Module: fb_phase_meter

Interface
REQ-001 Parameter CNT_W, default 24, SHALL set the width of the period/lag counters and outputs.
REQ-002 Parameter AVG_LOG2, default 2, SHALL set the number of averaged reference periods to 2^AVG_LOG2.
REQ-003 Clock  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Rst_n  input  1  reset, SHALL be asynchronous and active-low.
REQ-005 SigRef  input  1  asynchronous reference square wave, e.g. a DDS sign output.
REQ-006 SigFb  input  1  asynchronous feedback square wave, measured against SigRef.
REQ-007 Start  input  1  one-cycle request to begin a measurement.
REQ-008 Busy  output  1  high while a measurement is in progress.
REQ-009 Done  output  1  one-cycle pulse when results are updated.
REQ-010 Period  output  CNT_W  averaged SigRef period, in Clock cycles.
REQ-011 PhaseLag  output  CNT_W  Clock cycles from SigRef rise to the next SigFb rise.
REQ-012 Timeout  output  1  measurement aborted: no SigRef edge within the counter range.

Function
REQ-013 Each of SigRef and SigFb SHALL pass a 2-flop synchronizer, then a third register for rising-edge detect (sync2 & ~sync3); a pin edge SHALL be detected 3 cycles after it is sampled.
REQ-014 The FSM SHALL have states IDLE, ARM, MEAS and DONE; Busy SHALL be high in ARM and MEAS only.
REQ-015 IDLE->ARM on Start; Start SHALL be ignored in ARM, MEAS and DONE.
REQ-016 On entry to ARM, the period counter, accumulator, period index and lag-seen flag SHALL be cleared.
REQ-017 ARM->MEAS on the first detected SigRef rise; that edge SHALL load period counter=1 and lag counter=0, and arm the lag counter.
REQ-018 In MEAS, the period counter SHALL increment every cycle; on each detected SigRef rise it SHALL add its value to an accumulator (width CNT_W+AVG_LOG2), then reload to 1, increment the period index, and re-arm the lag counter from 0.
REQ-019 While armed, the lag counter SHALL increment every cycle; on a detected SigFb rise it SHALL latch the lag counter into an internal lag register, set lag-seen, and disarm.
REQ-020 When SigRef and SigFb rises are detected in the same cycle: latched lag=0, lag counter disarmed.
REQ-021 SigFb rises while disarmed, or in ARM, SHALL be ignored.
REQ-022 When the period index reaches 2^AVG_LOG2: MEAS->DONE; Period=accumulator>>AVG_LOG2 (truncating); PhaseLag=latched lag if lag-seen, else all-ones; Timeout=0.
REQ-023 If the period counter reaches all-ones in ARM or MEAS without a SigRef rise: ->DONE; Period=0; PhaseLag=0; Timeout=1.
REQ-024 DONE SHALL last exactly one cycle, with Done=1, then ->IDLE.
REQ-025 Period, PhaseLag and Timeout SHALL change only in the DONE cycle and hold until the next DONE.
REQ-026 The counters SHALL saturate, never wrap; saturation SHALL be handled by REQ-023.

Reset
REQ-027 Rst_n low SHALL force, immediately: IDLE; Busy=0, Done=0, Period=0, PhaseLag=0, Timeout=0; synchronizers, counters, accumulator, index and flags cleared.
REQ-028 Reset asserted mid-measurement SHALL abort it with no Done pulse; after release, the block SHALL wait in IDLE for Start.
REQ-029 Release of Rst_n SHALL NOT itself start a measurement.

Verification
REQ-030 Defaults. SigRef period=100 cycles, 50% duty; SigFb = SigRef delayed 25 cycles; pulse Start -> Busy=1; after 4 periods following the first detected rise, Done=1 for 1 cycle; Period=100, PhaseLag=25, Timeout=0.
REQ-031 SigRef periods 100,101,100,101 -> Period=100 (truncated 402/4); SigFb in phase with SigRef (simultaneous edges) -> PhaseLag=0.
REQ-032 CNT_W=8, SigRef held low, Start -> Done after ~255 cycles with Timeout=1, Period=0, PhaseLag=0, Busy=0.
REQ-033 SigFb held low, SigRef period 64 -> Period=64, PhaseLag=all-ones, Timeout=0.
REQ-034 Rst_n pulsed low during MEAS -> outputs 0 at once, no Done; Start re-pulsed during Busy -> ignored (Done count=1 per measurement).
REQ-035 A SigRef glitch shorter than 1 cycle that is not sampled -> no edge counted; results equal the glitch-free case.

Source files
------------

// File: rtl/fb_phase_meter.sv
// Phase meter: measures the averaged SigRef period and the SigRef-rise to SigFb-rise lag.
// Both inputs are asynchronous and pass through 2-flop synchronizers before edge detection.
module fb_phase_meter #(
    parameter int CNT_W    = 24,
    parameter int AVG_LOG2 = 2
) (
    input  logic             Clock,
    input  logic             Rst_n,
    input  logic             SigRef,
    input  logic             SigFb,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Period,
    output logic [CNT_W-1:0] PhaseLag,
    output logic             Timeout
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] NAVG    = (AVG_LOG2+1)'(2 ** AVG_LOG2);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

    state_t            state;
    logic [2:0]        ref_sync, fb_sync;
    logic [CNT_W-1:0]  per_cnt, lag_cnt, lag_q;
    logic [ACC_W-1:0]  acc;
    logic [AVG_LOG2:0] idx;
    logic              lag_armed, lag_seen;

    logic              ref_rise, fb_rise;
    logic [ACC_W-1:0]  acc_sum;
    logic [AVG_LOG2:0] idx_inc;
    logic [CNT_W-1:0]  lag_inc;

    assign ref_rise = ref_sync[1] & ~ref_sync[2];
    assign fb_rise  = fb_sync[1] & ~fb_sync[2];
    assign acc_sum  = acc + ACC_W'(per_cnt);
    assign idx_inc  = idx + 1'b1;
    // Lag counts the edge cycle itself, so a SigFb rise k cycles after SigRef latches k.
    assign lag_inc  = (lag_cnt == CNT_MAX) ? CNT_MAX : lag_cnt + 1'b1;

    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            ref_sync <= '0;
            fb_sync  <= '0;
        end else begin
            ref_sync <= {ref_sync[1:0], SigRef};
            fb_sync  <= {fb_sync[1:0], SigFb};
        end
    end

    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Period    <= '0;
            PhaseLag  <= '0;
            Timeout   <= 1'b0;
            per_cnt   <= '0;
            lag_cnt   <= '0;
            lag_q     <= '0;
            acc       <= '0;
            idx       <= '0;
            lag_armed <= 1'b0;
            lag_seen  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        state     <= ARM;
                        Busy      <= 1'b1;
                        per_cnt   <= '0;
                        acc       <= '0;
                        idx       <= '0;
                        lag_seen  <= 1'b0;
                        lag_armed <= 1'b0;
                    end
                end
                ARM, MEAS: begin
                    if (ref_rise) begin
                        per_cnt   <= CNT_W'(1);
                        lag_cnt   <= '0;
                        lag_armed <= ~fb_rise;
                        if (fb_rise) begin
                            lag_q    <= '0;
                            lag_seen <= 1'b1;
                        end
                        if (state == ARM) begin
                            state <= MEAS;
                        end else begin
                            acc <= acc_sum;
                            idx <= idx_inc;
                            if (idx_inc == NAVG) begin
                                state    <= DONE;
                                Busy     <= 1'b0;
                                Done     <= 1'b1;
                                Period   <= CNT_W'(acc_sum >> AVG_LOG2);
                                PhaseLag <= lag_seen ? lag_q : CNT_MAX;
                                Timeout  <= 1'b0;
                            end
                        end
                    end else if (per_cnt == CNT_MAX) begin
                        state    <= DONE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        Period   <= '0;
                        PhaseLag <= '0;
                        Timeout  <= 1'b1;
                    end else begin
                        per_cnt <= per_cnt + 1'b1;
                        if (state == MEAS && lag_armed) begin
                            if (fb_rise) begin
                                lag_q     <= lag_inc;
                                lag_seen  <= 1'b1;
                                lag_armed <= 1'b0;
                            end else begin
                                lag_cnt <= lag_inc;
                            end
                        end
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
